// File: rtl/vga_capture.sv
// VGA pin-level capture: recovers line/frame timing, verifies it against the configured
// geometry and emits active pixels with coordinates. Define VGA_CAPTURE_CHECKSUM_EN for frame_sum.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic        vga_blank_n,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [23:0] pix_data,
    output logic        frame_start,
    output logic        locked,
    output logic        err,
    output logic [7:0]  err_cnt,
    output logic [31:0] frame_sum
);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [10:0] HCNT_MAX   = 11'h7FF;
    localparam logic [9:0]  LINE_MAX   = 10'h3FF;
    localparam logic [11:0] H_TOTAL_L  = 12'(H_TOTAL);
    localparam logic [10:0] H_ACTIVE_L = 11'(H_ACTIVE);
    localparam logic [9:0]  V_TOTAL_L  = 10'(V_TOTAL);
    localparam logic [9:0]  V_ACTIVE_L = 10'(V_ACTIVE);

    // Input sampling (S1) and edge-detect history (S2)
    logic        hs_s1_q, vs_s1_q, bl_s1_q;
    logic [23:0] rgb_s1_q;
    logic        hs_s2_q, vs_s2_q;

    // Timing recovery
    logic [10:0] hcnt_q, hcnt_d;
    logic [10:0] run_q, run_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic [9:0]  act_q, act_d;
    logic [1:0]  state_q, state_d;
    logic        acq_bad_q, acq_bad_d;

    // Output registers
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic [23:0] pix_data_q, pix_data_d;
    logic        frame_start_q, frame_start_d;
    logic        err_q;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        hs_fall, vs_fall;
    logic [11:0] line_len;
    logic        line_has_px;
    logic [9:0]  act_line;
    logic [9:0]  lines_meas;
    logic [10:0] x_cur;
    logic [9:0]  y_cur;
    logic        line_err, frame_err, sat_err, range_err;
    logic        err_now;

    assign hs_fall = hs_s2_q & ~hs_s1_q;
    assign vs_fall = vs_s2_q & ~vs_s1_q;

    // The line that ends on an hsync fall is accounted for before any coincident frame check.
    assign line_len    = {1'b0, hcnt_q} + 12'd1;
    assign line_has_px = (run_q != 11'd0);
    assign act_line    = (hs_fall && line_has_px && act_q != LINE_MAX) ? act_q + 10'd1 : act_q;
    assign lines_meas  = (hs_fall && vcnt_q != LINE_MAX) ? vcnt_q + 10'd1 : vcnt_q;

    // The cycle of an hsync fall is the first cycle of the new line
    assign x_cur = hs_fall ? 11'd0 : run_q;
    assign y_cur = vs_fall ? 10'd0 : act_line;

    assign line_err  = hs_fall && ((line_len != H_TOTAL_L) ||
                                   (line_has_px && run_q != H_ACTIVE_L));
    assign frame_err = vs_fall && ((lines_meas != V_TOTAL_L) || (act_line != V_ACTIVE_L));
    assign sat_err   = !hs_fall && (hcnt_q == HCNT_MAX - 11'd1);
    assign range_err = bl_s1_q && ((x_cur >= H_ACTIVE_L) || (y_cur >= V_ACTIVE_L));

    assign err_now = (state_q != ST_SEARCH) && (line_err || frame_err || sat_err || range_err);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        acq_bad_d = acq_bad_q;
        case (state_q)
            ST_SEARCH: begin
                if (vs_fall) begin
                    state_d   = ST_ACQUIRE;
                    acq_bad_d = 1'b0;
                end
            end
            ST_ACQUIRE: begin
                if (vs_fall) begin
                    acq_bad_d = 1'b0;
                    if (!acq_bad_q && !err_now) begin
                        state_d = ST_LOCKED;
                    end
                end else if (err_now) begin
                    acq_bad_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (err_now) begin
                    state_d = ST_SEARCH;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        hcnt_d = hs_fall ? 11'd0 : ((hcnt_q == HCNT_MAX) ? HCNT_MAX : hcnt_q + 11'd1);
        if (hs_fall) begin
            run_d = {10'd0, bl_s1_q};
        end else if (bl_s1_q && run_q != HCNT_MAX) begin
            run_d = run_q + 11'd1;
        end else begin
            run_d = run_q;
        end
        vcnt_d = vs_fall ? 10'd0 : lines_meas;
        act_d  = vs_fall ? 10'd0 : act_line;
    end

    always_comb begin
        // A pixel coinciding with a mismatch is dropped together with the lock
        pix_valid_d   = (state_q == ST_LOCKED) && !err_now && bl_s1_q;
        pix_x_d       = pix_valid_d ? x_cur[9:0] : pix_x_q;
        pix_y_d       = pix_valid_d ? y_cur : pix_y_q;
        pix_data_d    = pix_valid_d ? rgb_s1_q : pix_data_q;
        frame_start_d = vs_fall && (state_d == ST_LOCKED);
        err_cnt_d     = (err_now && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            hs_s1_q       <= 1'b0;
            vs_s1_q       <= 1'b0;
            bl_s1_q       <= 1'b0;
            rgb_s1_q      <= '0;
            hs_s2_q       <= 1'b0;
            vs_s2_q       <= 1'b0;
            hcnt_q        <= '0;
            run_q         <= '0;
            vcnt_q        <= '0;
            act_q         <= '0;
            state_q       <= ST_SEARCH;
            acq_bad_q     <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_data_q    <= '0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            hs_s1_q       <= vga_hsync;
            vs_s1_q       <= vga_vsync;
            bl_s1_q       <= vga_blank_n;
            rgb_s1_q      <= {vga_r, vga_g, vga_b};
            hs_s2_q       <= hs_s1_q;
            vs_s2_q       <= vs_s1_q;
            hcnt_q        <= hcnt_d;
            run_q         <= run_d;
            vcnt_q        <= vcnt_d;
            act_q         <= act_d;
            state_q       <= state_d;
            acq_bad_q     <= acq_bad_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
            frame_start_q <= frame_start_d;
            err_q         <= err_now;
            err_cnt_q     <= err_cnt_d;
        end
    end

`ifdef VGA_CAPTURE_CHECKSUM_EN
    logic [31:0] acc_q, acc_d;
    logic [31:0] frame_sum_q, frame_sum_d;
    logic [31:0] acc_add;

    assign acc_add = pix_valid_d ? {8'd0, rgb_s1_q} : 32'd0;

    // The accumulator only runs while locked, so it starts every locked frame from zero
    always_comb begin
        acc_d       = acc_q;
        frame_sum_d = frame_sum_q;
        if (state_q != ST_LOCKED) begin
            acc_d = 32'd0;
        end else if (vs_fall) begin
            frame_sum_d = acc_q;
            acc_d       = acc_add;
        end else begin
            acc_d = acc_q + acc_add;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            frame_sum_q <= '0;
        end else begin
            acc_q       <= acc_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum = frame_sum_q;
`else
    assign frame_sum = 32'd0;
`endif

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_data    = pix_data_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == ST_LOCKED);
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 8x4 active / 16x8 total geometry.
module tb_vga_capture;

    localparam int HA = 8;
    localparam int VA = 4;
    localparam int HT = 16;
    localparam int VT = 8;

`ifdef VGA_CAPTURE_CHECKSUM_EN
    localparam logic [31:0] EXP_SUM = 32'(HA * VA);
`else
    localparam logic [31:0] EXP_SUM = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        hs, vs, bl;
    logic [7:0]  r, g, b;
    logic        pix_valid;
    logic [9:0]  pix_x, pix_y;
    logic [23:0] pix_data;
    logic        frame_start, locked, err;
    logic [7:0]  err_cnt;
    logic [31:0] frame_sum;

    vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT)) dut (
        .clk(clk), .rst(rst),
        .vga_hsync(hs), .vga_vsync(vs), .vga_blank_n(bl),
        .vga_r(r), .vga_g(g), .vga_b(b),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .frame_start(frame_start), .locked(locked), .err(err),
        .err_cnt(err_cnt), .frame_sum(frame_sum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pins driven one and two cycles ago; outputs seen now belong to the older one
    logic        h1_bl, h2_bl;
    logic [9:0]  h1_x, h1_y, h2_x, h2_y;
    logic [23:0] h1_d, h2_d;

    int          n_valid, n_pix_bad, n_err, n_fs, lock_rise_idx, fs_idx, cur_idx;
    logic [31:0] fs_sum;
    logic        prev_locked;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_valid       = 0;
        n_pix_bad     = 0;
        n_err         = 0;
        n_fs          = 0;
        lock_rise_idx = -1;
        fs_idx        = -1;
        fs_sum        = 32'hDEAD_BEEF;
    endtask

    task automatic observe();
        if (pix_valid === 1'b1) begin
            n_valid++;
            if (!(h2_bl === 1'b1 && pix_x === h2_x && pix_y === h2_y && pix_data === h2_d))
                n_pix_bad++;
        end
        if (err === 1'b1) n_err++;
        if (frame_start === 1'b1) begin
            n_fs++;
            fs_idx = cur_idx;
            fs_sum = frame_sum;
        end
        if (locked === 1'b1 && prev_locked === 1'b0) lock_rise_idx = cur_idx;
        prev_locked = locked;
    endtask

    task automatic drive_cycle(input logic hs_v, input logic vs_v, input logic bl_v,
                               input logic [9:0] x, input logic [9:0] y, input logic [23:0] d);
        @(negedge clk);
        observe();
        h2_bl = h1_bl; h2_x = h1_x; h2_y = h1_y; h2_d = h1_d;
        h1_bl = bl_v;  h1_x = x;    h1_y = y;    h1_d = d;
        hs = hs_v;
        vs = vs_v;
        bl = bl_v;
        {r, g, b} = bl_v ? d : 24'h0;
    endtask

    // One frame: hsync low cols 0-1, vsync low lines 0-1, active lines 2..5 cols 4..11
    task automatic drive_frame(input int short_line, input int run_line, input bit const_pix,
                               input int start_at, input int stop_at);
        int          idx;
        logic        act;
        logic [9:0]  xv, yv;
        logic [23:0] d;
        for (int l = 0; l < VT; l++) begin
            for (int c = 0; c < HT; c++) begin
                idx = l * HT + c;
                if (idx < start_at) continue;
                if (l == short_line && c == HT - 1) continue;
                act = (l >= 2) && (l < 2 + VA) && (c >= 4) && (c < 4 + HA) &&
                      !(l == run_line && c == 4 + HA - 1);
                xv = 10'(c - 4);
                yv = 10'(l - 2);
                d  = const_pix ? 24'h000001 : {xv[7:0], yv[7:0], 8'h5A};
                cur_idx = idx;
                drive_cycle(c >= 2, l >= 2, act, xv, yv, d);
                if (idx == stop_at) return;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        hs = 1'b1; vs = 1'b1; bl = 1'b0; r = 8'd0; g = 8'd0; b = 8'd0;
        h1_bl = 1'b0; h2_bl = 1'b0;
        h1_x = '0; h1_y = '0; h2_x = '0; h2_y = '0; h1_d = '0; h2_d = '0;
        prev_locked = 1'b0;
        cur_idx = 0;
        clear_stats();

        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_frame_sum", frame_sum, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Frame A: acquisition
        clear_stats();
        drive_frame(-1, -1, 1'b0, 0, -1);
        check("acq_valid", n_valid, 0);
        check("acq_locked", {31'd0, locked}, 32'd0);
        check("acq_err", n_err, 0);

        // Frame B: lock two cycles after the vsync fall, pixels flow
        clear_stats();
        drive_frame(-1, -1, 1'b0, 0, -1);
        check("lock_rise_idx", lock_rise_idx, 2);
        check("fs_idx", fs_idx, 2);
        check("lockB_valid", n_valid, HA * VA);
        check("lockB_pix", n_pix_bad, 0);
        check("lockB_err", n_err, 0);

        // Frame C: steady state
        clear_stats();
        drive_frame(-1, -1, 1'b0, 0, -1);
        check("frameC_valid", n_valid, HA * VA);
        check("frameC_pix", n_pix_bad, 0);
        check("frameC_fs", n_fs, 1);
        check("frameC_err_cnt", {24'd0, err_cnt}, 32'd0);

        // Line 3 one clock short
        clear_stats();
        drive_frame(3, -1, 1'b0, 0, -1);
        check("short_err", n_err, 1);
        check("short_valid", n_valid, 2 * HA);
        check("short_err_cnt", {24'd0, err_cnt}, 32'd1);
        check("short_locked", {31'd0, locked}, 32'd0);

        clear_stats();
        drive_frame(-1, -1, 1'b0, 0, -1);
        check("short_acq_valid", n_valid, 0);
        check("short_acq_locked", {31'd0, locked}, 32'd0);
        clear_stats();
        drive_frame(-1, -1, 1'b0, 0, -1);
        check("short_relock_idx", lock_rise_idx, 2);
        check("short_relock_valid", n_valid, HA * VA);

        // Line 3 with one active pixel missing
        clear_stats();
        drive_frame(-1, 3, 1'b0, 0, -1);
        check("run_err", n_err, 1);
        check("run_valid", n_valid, 2 * HA - 1);
        check("run_err_cnt", {24'd0, err_cnt}, 32'd2);
        check("run_locked", {31'd0, locked}, 32'd0);

        clear_stats();
        drive_frame(-1, -1, 1'b0, 0, -1);
        check("run_acq_valid", n_valid, 0);
        clear_stats();
        drive_frame(-1, -1, 1'b0, 0, -1);
        check("run_relock_idx", lock_rise_idx, 2);
        check("run_relock_valid", n_valid, HA * VA);

        // hsync lost: held high long enough to saturate the line counter
        clear_stats();
        cur_idx = 1000;
        for (int i = 0; i < 2100; i++) drive_cycle(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 24'd0);
        check("hold_err", n_err, 1);
        check("hold_err_cnt", {24'd0, err_cnt}, 32'd3);
        check("hold_locked", {31'd0, locked}, 32'd0);

        clear_stats();
        drive_frame(-1, -1, 1'b0, 0, -1);
        check("hold_acq_err", n_err, 0);

        // Locked frame of constant pixels, checksum read at the next frame_start
        clear_stats();
        drive_frame(-1, -1, 1'b1, 0, -1);
        check("const_valid", n_valid, HA * VA);
        check("const_pix", n_pix_bad, 0);

        // Next frame; reset while pixel (3,2) is on the pins
        clear_stats();
        drive_frame(-1, -1, 1'b0, 0, 4 * HT + 7);
        check("sum_fs", n_fs, 1);
        check("frame_sum", fs_sum, EXP_SUM);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        check("mid_rst_pix_x", {22'd0, pix_x}, 32'd0);
        check("mid_rst_pix_y", {22'd0, pix_y}, 32'd0);
        check("mid_rst_pix_data", {8'd0, pix_data}, 32'd0);
        check("mid_rst_frame_start", {31'd0, frame_start}, 32'd0);
        check("mid_rst_locked", {31'd0, locked}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        check("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("mid_rst_frame_sum", frame_sum, 32'd0);
        rst = 1'b0;

        clear_stats();
        drive_frame(-1, -1, 1'b0, 4 * HT + 8, -1);
        check("post_rst_valid", n_valid, 0);

        clear_stats();
        drive_frame(-1, -1, 1'b0, 0, -1);
        check("post_rst_acq_valid", n_valid, 0);
        check("post_rst_acq_locked", {31'd0, locked}, 32'd0);

        clear_stats();
        drive_frame(-1, -1, 1'b0, 0, -1);
        check("post_rst_lock_idx", lock_rise_idx, 2);
        check("post_rst_valid_lock", n_valid, HA * VA);
        check("post_rst_pix", n_pix_bad, 0);
        check("post_rst_err_cnt", {24'd0, err_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
